// File: rtl/stream_demux_reg_pkg.sv
`timescale 1ns/1ps
// stream_demux_reg_pkg: small shared helpers for the registered stream demux.
package stream_demux_reg_pkg;

  // Per-slot action taken on a clock edge.
  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_DRAIN = 2'd2
  } slot_op_e;

  // True when a destination index addresses an existing output.
  function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction

endpackage

// File: rtl/stream_demux_reg_slot.sv
`timescale 1ns/1ps
// stream_demux_reg_slot: one-entry output register (valid + payload) for one
// demux output. A load always wins over a drain, so a beat arriving while the
// held beat leaves replaces it in the same edge and valid stays high.
module stream_demux_reg_slot
  import stream_demux_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32'd32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  free_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  slot_op_e              w_op;

  // A draining slot counts as free so the same output can stream every cycle.
  assign free_o  = !r_valid || ready_i;
  assign valid_o = r_valid;
  assign data_o  = r_data;

  // Pick this edge's action: load beats drain, drain only when not reloaded.
  always_comb begin
    w_op = SLOT_HOLD;
    if (load_i) begin
      w_op = SLOT_LOAD;
    end else if (r_valid && ready_i) begin
      w_op = SLOT_DRAIN;
    end
  end

  // Slot state; payload is only written on a load and is kept after a drain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (w_op)
        SLOT_LOAD: begin
          r_valid <= 1'b1;
          r_data  <= data_i;
        end
        SLOT_DRAIN: r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux_reg.sv
`timescale 1ns/1ps
// stream_demux_reg: registered valid/ready demultiplexer. Each output owns a
// one-entry register; beats with an out-of-range select are accepted, dropped
// and flagged on the sticky err_o.
module stream_demux_reg
  import stream_demux_reg_pkg::*;
#(
  parameter int unsigned N_OUP      = 32'd2,
  parameter int unsigned DATA_WIDTH = 32'd32,
  parameter int unsigned LOG_N_OUP  = (N_OUP > 1) ? $clog2(N_OUP) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        inp_valid_i,
  output logic                        inp_ready_o,
  input  logic [DATA_WIDTH-1:0]       inp_data_i,
  input  logic [LOG_N_OUP-1:0]        oup_sel_i,
  output logic [N_OUP-1:0]            oup_valid_o,
  input  logic [N_OUP-1:0]            oup_ready_i,
  output logic [N_OUP*DATA_WIDTH-1:0] oup_data_o,
  output logic                        err_o,
  input  logic                        err_clr_i
);

  logic [LOG_N_OUP-1:0] w_sel;
  logic                 w_in_range;
  logic                 w_drop;
  logic [N_OUP-1:0]     w_hit;
  logic [N_OUP-1:0]     w_free;
  logic [N_OUP-1:0]     w_load;
  logic                 r_err;

  // With a single output the select carries no information and is ignored.
  if (N_OUP == 1) begin : g_single
    assign w_sel = '0;
  end else begin : g_multi
    assign w_sel = oup_sel_i;
  end

  assign w_in_range = idx_in_range(32'(w_sel), N_OUP);
  assign w_drop     = inp_valid_i && !w_in_range;

  // Out-of-range beats are always swallowed; otherwise follow the target slot.
  assign inp_ready_o = !w_in_range || (|(w_hit & w_free));
  assign err_o       = r_err;

  genvar gi;
  for (gi = 0; gi < N_OUP; gi++) begin : g_slot
    assign w_hit[gi]  = (w_sel == LOG_N_OUP'(gi));
    assign w_load[gi] = inp_valid_i && w_hit[gi] && w_free[gi];

    stream_demux_reg_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (w_load[gi]),
      .data_i  (inp_data_i),
      .ready_i (oup_ready_i[gi]),
      .free_o  (w_free[gi]),
      .valid_o (oup_valid_o[gi]),
      .data_o  (oup_data_o[gi*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_drop) begin
      r_err <= 1'b1;
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end

endmodule
